// File: rtl/adder_accum_core_if.sv
// Operand/result handshake bundle for adder_accum_core.
// master drives operands and out_ready; slave is the datapath.
`timescale 1ns/1ps
interface adder_accum_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, carry, ovf
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, carry, ovf
    );
endinterface

// File: rtl/adder_accum_core.sv
// Registered ADD/SUB/ACC/CLR datapath with ready/valid handshake.
// Define ADDER_ACCUM_SAT_EN to saturate results instead of wrapping.
`timescale 1ns/1ps
module adder_accum_core #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    adder_accum_if.slave       bus,
    output logic [COUNT_W-1:0] acc_cnt
);
    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic               ovf_q;
    logic               vld_q;
    logic [COUNT_W-1:0] cnt_q;

    logic               is_add;
    logic               is_sub;
    logic               is_acc;
    logic               is_clr;
    logic               in_fire;
    logic               out_fire;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res_d;
    logic               carry_d;
    logic               ovf_d;

    assign is_add = (bus.mode == MODE_ADD);
    assign is_sub = (bus.mode == MODE_SUB);
    assign is_acc = (bus.mode == MODE_ACC);
    assign is_clr = (bus.mode == MODE_CLR);

    // A full register may be drained and refilled in the same cycle.
    assign bus.in_ready = ena && (!vld_q || bus.out_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = ena && vld_q && bus.out_ready;

    assign opa  = is_acc ? acc_q : bus.a;
    assign opb  = is_acc ? bus.a : bus.b;
    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (1'b1)
            is_add, is_acc: begin
                res_d   = sum[MSB:0];
                carry_d = sum[WIDTH];
                ovf_d   = (opa[MSB] == opb[MSB])
                       && (sum[MSB] != opa[MSB]);
`ifdef ADDER_ACCUM_SAT_EN
                if (sum[WIDTH]) res_d = '1;
`endif
            end
            is_sub: begin
                res_d   = diff[MSB:0];
                carry_d = diff[WIDTH];
                ovf_d   = (bus.a[MSB] != bus.b[MSB])
                       && (diff[MSB] != bus.a[MSB]);
`ifdef ADDER_ACCUM_SAT_EN
                if (diff[WIDTH]) res_d = '0;
`endif
            end
            is_clr: begin
                res_d   = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
            default: begin
                res_d   = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (in_fire) begin
            vld_q   <= 1'b1;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end else if (out_fire) begin
            vld_q   <= 1'b0;
        end
    end

    // Accumulator state moves only on ACC/CLR beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (in_fire && is_acc) begin
            acc_q <= res_d;
            if (!(&cnt_q)) cnt_q <= cnt_q + COUNT_W'(1);
        end else if (in_fire && is_clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign acc_cnt       = cnt_q;
endmodule

// File: tb/tb_adder_accum_core.sv
// Scoreboard bench for adder_accum_core.
// Expected beats are queued at accept and compared at output transfer.
`timescale 1ns/1ps
module tb_adder_accum_core;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena   = 1'b0;
    logic [CW-1:0] acc_cnt;

    adder_accum_if #(.WIDTH(W)) bus ();

    adder_accum_core #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .bus     (bus.slave),
        .acc_cnt (acc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int v;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_acc = 0;
    int   m_cnt = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(int a, int b, int m);
        exp_t e;
        int   x;
        int   y;
        int   s;
        e.r = 0;
        e.c = 0;
        e.v = 0;
        if (m == 0 || m == 2) begin
            x   = (m == 2) ? m_acc : a;
            y   = (m == 2) ? a : b;
            s   = x + y;
            e.r = s % 256;
            e.c = (s >= 256) ? 1 : 0;
            e.v = (((x >= 128) == (y >= 128)) &&
                   ((e.r >= 128) != (x >= 128))) ? 1 : 0;
`ifdef ADDER_ACCUM_SAT_EN
            if (e.c == 1) e.r = 255;
`endif
            if (m == 2) begin
                m_acc = e.r;
                if (m_cnt < 15) m_cnt++;
            end
        end else if (m == 1) begin
            e.r = (a - b + 256) % 256;
            e.c = (a < b) ? 1 : 0;
            e.v = (((a >= 128) != (b >= 128)) &&
                   ((e.r >= 128) != (a >= 128))) ? 1 : 0;
`ifdef ADDER_ACCUM_SAT_EN
            if (e.c == 1) e.r = 0;
`endif
        end else begin
            m_acc = 0;
            m_cnt = 0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ena && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("result", bus.result, e.r);
                check("carry", bus.carry, e.c);
                check("ovf", bus.ovf, e.v);
            end
        end
    end

    task automatic send(int a, int b, int m);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        bus.a        = a[W-1:0];
        bus.b        = b[W-1:0];
        bus.mode     = m[1:0];
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sbq.push_back(model(a, b, m));
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (ok) check("latency_valid", bus.out_valid, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_cnt;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_carry", bus.carry, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_cnt", acc_cnt, 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.in_ready, 1);

        send(0, 0, 0);
        send(10, 15, 0);
        send(20, 30, 0);
        send(255, 1, 0);
        send(128, 128, 0);
        send(5, 10, 1);
        send(127, 255, 1);
        send(200, 100, 1);
        drain();

        send(0, 0, 3);
        send(100, 0, 2);
        send(100, 0, 2);
        send(100, 0, 2);
        drain();
        check("acc_cnt_model", acc_cnt, m_cnt);
        check("acc_cnt_three", acc_cnt, 3);
        send(0, 0, 3);
        drain();
        check("acc_cnt_clr", acc_cnt, 0);
        for (int i = 0; i < 17; i++) send(1, 0, 2);
        drain();
        check("acc_cnt_sat", acc_cnt, 15);
        send(0, 0, 3);
        drain();

        bus.out_ready = 1'b0;
        send(10, 15, 0);
        @(posedge clk);
        #1;
        bus.a        = 8'd20;
        bus.b        = 8'd5;
        bus.mode     = 2'b00;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", bus.in_ready, 0);
            check("bp_valid", bus.out_valid, 1);
            check("bp_result", bus.result, 25);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_refill_ready", bus.in_ready, 1);
        sbq.push_back(model(20, 5, 0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        send(0, 0, 3);
        send(100, 0, 2);
        drain();
        bus.out_ready = 1'b0;
        send(100, 0, 2);
        @(negedge clk);
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_result", bus.result, 200);
        check("pre_rst_cnt", acc_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", bus.out_valid, 0);
        check("async_result", bus.result, 0);
        check("async_cnt", acc_cnt, 0);
        sbq.delete();
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send(7, 0, 2);
        drain();

        bus.out_ready = 1'b0;
        send(3, 4, 0);
        @(posedge clk);
        #1;
        ena           = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = 8'd9;
        bus.b         = 8'd9;
        bus.mode      = 2'b10;
        bus.in_valid  = 1'b1;
        hold_cnt      = m_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ena_ready", bus.in_ready, 0);
            check("ena_valid", bus.out_valid, 1);
            check("ena_result", bus.result, 7);
            check("ena_cnt", acc_cnt, hold_cnt);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ena          = 1'b1;
        drain();
        send(1, 0, 2);
        drain();

        check("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
